if_pc_gen: RTL and testbench
============================

IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 Parameter RESET_ADDRESS, default 40'h0000_0100, first fetch PC after reset.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 next_pc_sel_i  in  2  next-PC selector from control unit: BP_OR_PC_4, JUMP, KEEP_PC, DEBUG.
REQ-005 sel_addr_if_i  in  2  jump source: DECODE, EXECUTION, CSR, DEBUG.
REQ-006 addr_decode_i / addr_exe_i / addr_csr_i / addr_debug_i  in  40 each  jump targets.
REQ-007 bp_taken_i  in  1, bp_target_i  in  40: branch-predictor hint for pc_q.
REQ-008 stall_if_i, flush_if_i, invalidate_icache_i, invalidate_buffer_i  in  1 each.
REQ-009 icache_req_valid_o  out  1, icache_req_addr_o  out  40, icache_req_ready_i  in  1.
REQ-010 icache_resp_valid_i  in  1, icache_resp_data_i  in  32, icache_resp_xcpt_i  in  1 (access fault).
REQ-011 icache_inval_o  out  1, icache_inval_ack_i  in  1.
REQ-012 valid_fetch_o  out  1 (to control unit and decode), fetch_o  out  if_id_t {pc 40, inst 32, xcpt_access 1, xcpt_misaligned 1}.

Function
REQ-013 pc_q update each cycle: BP_OR_PC_4 -> bp_target_i if bp_taken_i else pc_q+4 (40-bit wrap); KEEP_PC -> hold; DEBUG -> addr_debug_i; JUMP -> target chosen by sel_addr_if_i.
REQ-014 Redirect = next_pc_sel_i in {JUMP, DEBUG} or flush_if_i or invalidate_buffer_i.
REQ-015 One-entry fetch buffer; valid_fetch_o = buffer valid; fetch_o driven from buffer, zero when empty.
REQ-016 Buffer cleared on redirect or on BP_OR_PC_4 (consumption); redirect has priority over fill in the same cycle.
REQ-017 FSM states REQ, WAIT, KILL, INVAL.
REQ-018 REQ: icache_req_valid_o=1, addr=pc_q, only when buffer empty, no pending invalidate, pc_q[1:0]==0; ready -> WAIT, unless redirect same cycle -> KILL.
REQ-019 REQ with pc_q[1:0]!=0: no request; buffer filled next cycle with xcpt_misaligned=1, inst=0.
REQ-020 WAIT: resp_valid -> fill buffer (pc_q, data, xcpt), -> REQ; redirect before or with response -> KILL, response discarded.
REQ-021 KILL: discard next response, -> REQ (or INVAL if pending).
REQ-022 invalidate_icache_i sets sticky inval_pending; FSM enters INVAL from REQ, or after response from WAIT/KILL; never mid-transaction.
REQ-023 INVAL: icache_inval_o=1 held until icache_inval_ack_i; then clear pending, -> REQ; ack same cycle as entry accepted.
REQ-024 stall_if_i: no buffer consumption, no pc_q change regardless of selector; outstanding request still completes into buffer.
REQ-025 Fetch latency: request cycle N, response cycle N+k, valid_fetch_o in N+k+1.
REQ-026 At most one outstanding icache request at any time.

Reset
REQ-027 On rst_i: pc_q=RESET_ADDRESS, state=REQ, buffer empty, inval_pending=0, all outputs 0 except icache_req_valid_o=1 in first post-reset cycle.
REQ-028 Reset mid-WAIT: in-flight response ignored for one response (enter KILL equivalent after reset via kill_pending flag).

Structure
REQ-029 if_id_t, if_state_t and ADDR_SIZE=40 live in drac_pkg; existing next_pc and sel_addr enums reused.
REQ-030 One sub-module: if_fetch_buffer (one-entry buffer with fill/clear/valid).

Verification
REQ-031 Reset, ready=1, resp after 2 cycles data 32'h0000_0013 -> req addr 40'h100, valid_fetch_o with pc 40'h100, then request 40'h104.
REQ-032 JUMP/EXECUTION to 40'h2000 while WAIT -> KILL; stale response dropped; next request 40'h2000; no valid_fetch_o for old PC.
REQ-033 JUMP to 40'h2002 -> no icache request; valid_fetch_o with xcpt_misaligned=1, pc 40'h2002.
REQ-034 invalidate_icache_i during WAIT -> response delivered first, icache_inval_o asserted after, held 3 cycles until ack, then fetch resumes.
REQ-035 stall_if_i=1 for 4 cycles with buffer full -> pc_q, fetch_o constant, no new request; BP_OR_PC_4 with bp_taken_i, target 40'h3000 -> next request 40'h3000.
REQ-036 resp_xcpt_i=1 -> fetch_o.xcpt_access=1; rst_i in WAIT -> post-reset first response discarded, fetch restarts at 40'h100.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared types for the fetch front end: address width, next-PC and jump-source
// selectors, fetch FSM states and the IF->ID payload.
package drac_pkg;

    localparam int ADDR_SIZE = 40;
    localparam int INST_SIZE = 32;

    typedef enum logic [1:0] {
        NEXT_PC_SEL_BP_OR_PC_4 = 2'd0,
        NEXT_PC_SEL_JUMP       = 2'd1,
        NEXT_PC_SEL_KEEP_PC    = 2'd2,
        NEXT_PC_SEL_DEBUG      = 2'd3
    } next_pc_sel_t;

    typedef enum logic [1:0] {
        SEL_JUMP_DECODE    = 2'd0,
        SEL_JUMP_EXECUTION = 2'd1,
        SEL_JUMP_CSR       = 2'd2,
        SEL_JUMP_DEBUG     = 2'd3
    } jump_addr_fetch_t;

    typedef enum logic [1:0] {
        IF_REQ   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_KILL  = 2'd2,
        IF_INVAL = 2'd3
    } if_state_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [INST_SIZE-1:0] inst;
        logic                 xcpt_access;
        logic                 xcpt_misaligned;
    } if_id_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry holding register between the icache and decode.
// Flush beats fill, fill beats consume; the payload reads as zero while empty.
module if_fetch_buffer
    import drac_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   consume_i,
    input  logic   fill_i,
    input  if_id_t fill_data_i,
    output logic   valid_o,
    output if_id_t data_o
);

    logic   valid_q;
    if_id_t data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            data_q  <= fill_data_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = valid_q ? data_q : '0;

endmodule

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: owns pc_q, issues single outstanding icache
// requests, drops stale responses after redirects, and sequences icache invalidates.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IF_REQ   | idle/requesting pc_q when the buffer is empty
//   IF_WAIT  | request accepted, waiting for the icache response
//   IF_KILL  | redirected mid-flight, next response is dropped
//   IF_INVAL | icache_inval_o held high until icache_inval_ack_i
module if_pc_gen
    import drac_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0] RESET_ADDRESS = 40'h0000_0100
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  next_pc_sel_t         next_pc_sel_i,
    input  jump_addr_fetch_t     sel_addr_if_i,
    input  logic [ADDR_SIZE-1:0] addr_decode_i,
    input  logic [ADDR_SIZE-1:0] addr_exe_i,
    input  logic [ADDR_SIZE-1:0] addr_csr_i,
    input  logic [ADDR_SIZE-1:0] addr_debug_i,
    input  logic                 bp_taken_i,
    input  logic [ADDR_SIZE-1:0] bp_target_i,
    input  logic                 stall_if_i,
    input  logic                 flush_if_i,
    input  logic                 invalidate_icache_i,
    input  logic                 invalidate_buffer_i,
    output logic                 icache_req_valid_o,
    output logic [ADDR_SIZE-1:0] icache_req_addr_o,
    input  logic                 icache_req_ready_i,
    input  logic                 icache_resp_valid_i,
    input  logic [INST_SIZE-1:0] icache_resp_data_i,
    input  logic                 icache_resp_xcpt_i,
    output logic                 icache_inval_o,
    input  logic                 icache_inval_ack_i,
    output logic                 valid_fetch_o,
    output if_id_t               fetch_o
);

    if_state_t            state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d, req_pc_q, jump_addr;
    logic                 inval_pending_q, inval_pending_d, inval_pending_now, inval_done;
    logic                 kill_pending_q;
    logic                 redirect, consume, eff_resp, misaligned;
    logic                 buf_valid, fill, req_valid;
    if_id_t               fill_data;

    always_comb begin
        jump_addr = addr_decode_i;
        case (sel_addr_if_i)
            SEL_JUMP_DECODE:    jump_addr = addr_decode_i;
            SEL_JUMP_EXECUTION: jump_addr = addr_exe_i;
            SEL_JUMP_CSR:       jump_addr = addr_csr_i;
            SEL_JUMP_DEBUG:     jump_addr = addr_debug_i;
            default:            jump_addr = addr_decode_i;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (next_pc_sel_i)
            NEXT_PC_SEL_BP_OR_PC_4: pc_d = bp_taken_i ? bp_target_i : pc_q + 40'd4;
            NEXT_PC_SEL_JUMP:       pc_d = jump_addr;
            NEXT_PC_SEL_KEEP_PC:    pc_d = pc_q;
            NEXT_PC_SEL_DEBUG:      pc_d = addr_debug_i;
            default:                pc_d = pc_q;
        endcase
    end

    // A stalled jump leaves pc_q untouched, so it must not kill the in-flight fetch either.
    assign redirect = (!stall_if_i && (next_pc_sel_i == NEXT_PC_SEL_JUMP ||
                                       next_pc_sel_i == NEXT_PC_SEL_DEBUG))
                      || flush_if_i || invalidate_buffer_i;
    assign consume           = !stall_if_i && (next_pc_sel_i == NEXT_PC_SEL_BP_OR_PC_4);
    assign eff_resp          = icache_resp_valid_i && !kill_pending_q;
    assign misaligned        = (pc_q[1:0] != 2'b00);
    assign inval_pending_now = inval_pending_q || invalidate_icache_i;

    always_comb begin
        state_d        = state_q;
        req_valid      = 1'b0;
        icache_inval_o = 1'b0;
        fill           = 1'b0;
        fill_data      = '0;
        inval_done     = 1'b0;
        case (state_q)
            IF_REQ: begin
                if (inval_pending_q) begin
                    state_d = IF_INVAL;
                end else if (!buf_valid) begin
                    if (misaligned) begin
                        fill                      = !redirect;
                        fill_data.pc              = pc_q;
                        fill_data.xcpt_misaligned = 1'b1;
                    end else begin
                        req_valid = 1'b1;
                        if (icache_req_ready_i) state_d = redirect ? IF_KILL : IF_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                if (eff_resp) begin
                    // A redirect arriving with the response just drops it; nothing is left in flight.
                    fill                  = !redirect;
                    fill_data.pc          = req_pc_q;
                    fill_data.inst        = icache_resp_data_i;
                    fill_data.xcpt_access = icache_resp_xcpt_i;
                    state_d               = inval_pending_now ? IF_INVAL : IF_REQ;
                end else if (redirect) begin
                    state_d = IF_KILL;
                end
            end
            IF_KILL: begin
                if (eff_resp) state_d = inval_pending_now ? IF_INVAL : IF_REQ;
            end
            IF_INVAL: begin
                icache_inval_o = 1'b1;
                if (icache_inval_ack_i) begin
                    inval_done = 1'b1;
                    state_d    = IF_REQ;
                end
            end
            default: state_d = IF_REQ;
        endcase
    end

    assign inval_pending_d = (inval_pending_q && !inval_done) || invalidate_icache_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IF_REQ;
            pc_q            <= RESET_ADDRESS;
            req_pc_q        <= RESET_ADDRESS;
            inval_pending_q <= 1'b0;
            // Remember a response still owed by the icache so the first one after reset is dropped.
            kill_pending_q  <= ((state_q == IF_WAIT) || (state_q == IF_KILL) || kill_pending_q)
                               && !icache_resp_valid_i;
        end else begin
            state_q         <= state_d;
            inval_pending_q <= inval_pending_d;
            if (!stall_if_i) pc_q <= pc_d;
            if (req_valid && icache_req_ready_i) req_pc_q <= pc_q;
            if (icache_resp_valid_i) kill_pending_q <= 1'b0;
        end
    end

    assign icache_req_valid_o = req_valid;
    assign icache_req_addr_o  = req_valid ? pc_q : '0;

    if_fetch_buffer u_fetch_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect),
        .consume_i   (consume),
        .fill_i      (fill),
        .fill_data_i (fill_data),
        .valid_o     (buf_valid),
        .data_o      (fetch_o)
    );

    assign valid_fetch_o = buf_valid;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: the bench plays the icache by hand and checks
// requests, buffer contents, kills, invalidates, stalls and reset-in-flight.
module tb_if_pc_gen;
    import drac_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    next_pc_sel_t     next_pc_sel_i;
    jump_addr_fetch_t sel_addr_if_i;
    logic [39:0]      addr_decode_i, addr_exe_i, addr_csr_i, addr_debug_i;
    logic             bp_taken_i;
    logic [39:0]      bp_target_i;
    logic             stall_if_i, flush_if_i, invalidate_icache_i, invalidate_buffer_i;
    logic             icache_req_valid_o;
    logic [39:0]      icache_req_addr_o;
    logic             icache_req_ready_i;
    logic             icache_resp_valid_i;
    logic [31:0]      icache_resp_data_i;
    logic             icache_resp_xcpt_i;
    logic             icache_inval_o;
    logic             icache_inval_ack_i;
    logic             valid_fetch_o;
    if_id_t           fetch_o;

    int errors = 0;
    int checks = 0;

    if_pc_gen #(.RESET_ADDRESS(40'h0000_0100)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .next_pc_sel_i       (next_pc_sel_i),
        .sel_addr_if_i       (sel_addr_if_i),
        .addr_decode_i       (addr_decode_i),
        .addr_exe_i          (addr_exe_i),
        .addr_csr_i          (addr_csr_i),
        .addr_debug_i        (addr_debug_i),
        .bp_taken_i          (bp_taken_i),
        .bp_target_i         (bp_target_i),
        .stall_if_i          (stall_if_i),
        .flush_if_i          (flush_if_i),
        .invalidate_icache_i (invalidate_icache_i),
        .invalidate_buffer_i (invalidate_buffer_i),
        .icache_req_valid_o  (icache_req_valid_o),
        .icache_req_addr_o   (icache_req_addr_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_data_i  (icache_resp_data_i),
        .icache_resp_xcpt_i  (icache_resp_xcpt_i),
        .icache_inval_o      (icache_inval_o),
        .icache_inval_ack_i  (icache_inval_ack_i),
        .valid_fetch_o       (valid_fetch_o),
        .fetch_o             (fetch_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [39:0] a);
        chk({tag, "_req_valid"}, 64'(icache_req_valid_o), 64'(v));
        if (v) chk({tag, "_req_addr"}, 64'(icache_req_addr_o), 64'(a));
    endtask

    task automatic chk_fetch(input string tag, input logic v, input logic [39:0] pc,
                             input logic [31:0] inst, input logic xa, input logic xm);
        chk({tag, "_valid"}, 64'(valid_fetch_o), 64'(v));
        chk({tag, "_pc"},    64'(fetch_o.pc), 64'(pc));
        chk({tag, "_inst"},  64'(fetch_o.inst), 64'(inst));
        chk({tag, "_xa"},    64'(fetch_o.xcpt_access), 64'(xa));
        chk({tag, "_xm"},    64'(fetch_o.xcpt_misaligned), 64'(xm));
    endtask

    initial begin
        rst_i = 1'b1;
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        sel_addr_if_i = SEL_JUMP_DECODE;
        addr_decode_i = '0; addr_exe_i = '0; addr_csr_i = '0; addr_debug_i = '0;
        bp_taken_i = 1'b0; bp_target_i = '0;
        stall_if_i = 1'b0; flush_if_i = 1'b0;
        invalidate_icache_i = 1'b0; invalidate_buffer_i = 1'b0;
        icache_req_ready_i = 1'b1;
        icache_resp_valid_i = 1'b0; icache_resp_data_i = '0; icache_resp_xcpt_i = 1'b0;
        icache_inval_ack_i = 1'b0;

        // Reset state
        step(); step();
        chk_req("rst", 1'b1, 40'h100);
        chk_fetch("rst", 1'b0, 40'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_inval", 64'(icache_inval_o), 64'h0);

        // Basic fetch, response two cycles after the request
        rst_i = 1'b0;
        step();
        chk_req("wait0", 1'b0, 40'h0);
        step();
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h0000_0013;
        step();
        icache_resp_valid_i = 1'b0;
        chk_fetch("f100", 1'b1, 40'h100, 32'h0000_0013, 1'b0, 1'b0);
        chk_req("full", 1'b0, 40'h0);
        next_pc_sel_i = NEXT_PC_SEL_BP_OR_PC_4;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        chk_fetch("cons", 1'b0, 40'h0, 32'h0, 1'b0, 1'b0);
        chk_req("r104", 1'b1, 40'h104);

        // Jump while waiting: stale response dropped
        step();
        next_pc_sel_i = NEXT_PC_SEL_JUMP; sel_addr_if_i = SEL_JUMP_EXECUTION;
        addr_exe_i = 40'h2000;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        chk_req("kill", 1'b0, 40'h0);
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'hdead_beef;
        step();
        icache_resp_valid_i = 1'b0;
        chk("stale_valid", 64'(valid_fetch_o), 64'h0);
        chk_req("r2000", 1'b1, 40'h2000);

        // Misaligned jump: no request, exception entry in the buffer
        icache_req_ready_i = 1'b0;
        next_pc_sel_i = NEXT_PC_SEL_JUMP; addr_exe_i = 40'h2002;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        chk_req("mis", 1'b0, 40'h0);
        step();
        chk_fetch("mis", 1'b1, 40'h2002, 32'h0, 1'b0, 1'b1);
        chk_req("misfull", 1'b0, 40'h0);
        icache_req_ready_i = 1'b1;
        next_pc_sel_i = NEXT_PC_SEL_JUMP; addr_exe_i = 40'h400;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        chk("j400_valid", 64'(valid_fetch_o), 64'h0);
        chk_req("r400", 1'b1, 40'h400);

        // Invalidate during WAIT: response first, then INVAL held until ack
        step();
        invalidate_icache_i = 1'b1;
        step();
        invalidate_icache_i = 1'b0;
        chk("inv_wait", 64'(icache_inval_o), 64'h0);
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h0050_0093;
        step();
        icache_resp_valid_i = 1'b0;
        chk_fetch("f400", 1'b1, 40'h400, 32'h0050_0093, 1'b0, 1'b0);
        chk("inv_c1", 64'(icache_inval_o), 64'h1);
        chk_req("inv_c1", 1'b0, 40'h0);
        step();
        chk("inv_c2", 64'(icache_inval_o), 64'h1);
        step();
        chk("inv_c3", 64'(icache_inval_o), 64'h1);
        icache_inval_ack_i = 1'b1;
        step();
        icache_inval_ack_i = 1'b0;
        chk("inv_done", 64'(icache_inval_o), 64'h0);
        next_pc_sel_i = NEXT_PC_SEL_BP_OR_PC_4;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        chk_req("r404", 1'b1, 40'h404);

        // Stall with a full buffer, then a taken prediction
        step();
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h1111_1111;
        step();
        icache_resp_valid_i = 1'b0;
        chk_fetch("f404", 1'b1, 40'h404, 32'h1111_1111, 1'b0, 1'b0);
        stall_if_i = 1'b1;
        next_pc_sel_i = NEXT_PC_SEL_BP_OR_PC_4; bp_taken_i = 1'b1; bp_target_i = 40'h3000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_fetch("stall", 1'b1, 40'h404, 32'h1111_1111, 1'b0, 1'b0);
            chk_req("stall", 1'b0, 40'h0);
        end
        stall_if_i = 1'b0;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC; bp_taken_i = 1'b0;
        chk("bp_valid", 64'(valid_fetch_o), 64'h0);
        chk_req("r3000", 1'b1, 40'h3000);

        // Access fault response
        step();
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h0; icache_resp_xcpt_i = 1'b1;
        step();
        icache_resp_valid_i = 1'b0; icache_resp_xcpt_i = 1'b0;
        chk_fetch("xa", 1'b1, 40'h3000, 32'h0, 1'b1, 1'b0);
        next_pc_sel_i = NEXT_PC_SEL_BP_OR_PC_4;
        step();
        next_pc_sel_i = NEXT_PC_SEL_KEEP_PC;
        chk_req("r3004", 1'b1, 40'h3004);

        // Reset while waiting: first response afterwards is stale
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_req("rst2", 1'b1, 40'h100);
        chk_fetch("rst2", 1'b0, 40'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_req("rst2_wait", 1'b0, 40'h0);
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h0bad_0bad;
        step();
        icache_resp_valid_i = 1'b0;
        chk("rst2_stale", 64'(valid_fetch_o), 64'h0);
        chk_req("rst2_still", 1'b0, 40'h0);
        icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h0000_0013;
        step();
        icache_resp_valid_i = 1'b0;
        chk_fetch("rst2_f", 1'b1, 40'h100, 32'h0000_0013, 1'b0, 1'b0);

        // Flush empties the buffer without moving the PC
        flush_if_i = 1'b1;
        step();
        flush_if_i = 1'b0;
        chk("flush_valid", 64'(valid_fetch_o), 64'h0);
        chk_req("flush", 1'b1, 40'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
